// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if
// Request/result bundle between instruction decode, the ALU op sequencer and
// writeback.
//
// Signals (direction as seen by the sequencer, i.e. the slave modport):
//   op_valid   in   operation request present
//   op_ready   out  sequencer can accept a request
//   op_code    in   2-bit op: 00 AND, 01 OR, 10 ADD/SUB, 11 LESS (signed)
//   op_sub     in   with op_code 10: 1 = a-b, 0 = a+b
//   operand_a  in   first operand
//   operand_b  in   second operand
//   mux_sel    out  select code to the 4-to-1 result mux
//   res_valid  out  result available
//   res_ready  in   downstream accepts result
//   result     out  registered result
//   carry_out  out  ADD/SUB carry (SUB: 1 = no borrow)
//   zero       out  result == 0
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if #(
    parameter int WIDTH = 24
);
    logic             op_valid;
    logic             op_ready;
    logic [1:0]       op_code;
    logic             op_sub;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [1:0]       mux_sel;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             zero;

    // Requester / consumer side (decode + writeback).
    modport master (
        output op_valid, op_code, op_sub, operand_a, operand_b, res_ready,
        input  op_ready, mux_sel, res_valid, result, carry_out, zero
    );

    // Sequencer side.
    modport slave (
        input  op_valid, op_code, op_sub, operand_a, operand_b, res_ready,
        output op_ready, mux_sel, res_valid, result, carry_out, zero
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Issue side of the ALU result-select path. Accepts one operation per
// op_valid/op_ready handshake, registers the operands, evaluates AND, OR,
// ADD/SUB or signed LESS, drives the result-mux select code and holds the
// registered result until the downstream stage takes it.
//
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   asynchronous, active-high
//   bus    slave modport of alu_op_sequencer_if (handshake, operands, result)
//
// Flow: IDLE -accept-> EXEC -> DONE -res_ready-> IDLE
//       LESS takes one extra cycle: EXEC -> CMP -> DONE.
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int WIDTH = 24
) (
    input  logic                clk,
    input  logic                reset,
    alu_op_sequencer_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_CMP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [1:0]       code_q,   code_d;
    logic             sub_q,    sub_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q,  carry_d;
    logic             zero_q,   zero_d;
    logic             sign_q,   sign_d;
    logic             ovf_q,    ovf_d;

    // a + (sub ? ~b : b) + sub at WIDTH+1 bits; bit WIDTH is the carry
    // (for subtraction: 1 = no borrow).
    function automatic logic [WIDTH:0] add_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             sub);
        logic [WIDTH-1:0] bx;
        bx = sub ? ~b : b;
        return {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
    endfunction

    // Signed overflow of a - b: operand signs differ and the difference
    // sign disagrees with a.
    function automatic logic sub_overflow(input logic a_msb,
                                          input logic b_msb,
                                          input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

    // LESS always subtracts; op_sub only matters for ADD/SUB.
    logic [WIDTH:0] sum_w;
    assign sum_w = add_sub(a_q, b_q, (code_q == OP_LESS) | sub_q);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        code_d   = code_q;
        sub_d    = sub_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        sign_d   = sign_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.op_valid) begin
                    a_d     = bus.operand_a;
                    b_d     = bus.operand_b;
                    code_d  = bus.op_code;
                    sub_d   = bus.op_sub;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (code_q == OP_LESS) begin
                    sign_d  = sum_w[WIDTH-1];
                    ovf_d   = sub_overflow(a_q[WIDTH-1], b_q[WIDTH-1], sum_w[WIDTH-1]);
                    state_d = S_CMP;
                end else begin
                    case (code_q)
                        OP_AND:  begin result_d = a_q & b_q;          carry_d = 1'b0;         end
                        OP_OR:   begin result_d = a_q | b_q;          carry_d = 1'b0;         end
                        default: begin result_d = sum_w[WIDTH-1:0];   carry_d = sum_w[WIDTH]; end
                    endcase
                    zero_d  = (result_d == '0);
                    state_d = S_DONE;
                end
            end
            S_CMP: begin
                // Sign of the difference corrected by overflow gives a < b.
                result_d = {{(WIDTH-1){1'b0}}, sign_q ^ ovf_q};
                carry_d  = 1'b0;
                zero_d   = ~(sign_q ^ ovf_q);
                state_d  = S_DONE;
            end
            default: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            code_q   <= OP_AND;
            sub_q    <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            sign_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            code_q   <= code_d;
            sub_q    <= sub_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            sign_q   <= sign_d;
            ovf_q    <= ovf_d;
        end
    end

    // Handshake flags decode straight from state so reset clears them
    // without waiting for a clock edge.
    assign bus.op_ready  = (state_q == S_IDLE);
    assign bus.res_valid = (state_q == S_DONE);
    assign bus.mux_sel   = (state_q == S_IDLE) ? 2'b00 : code_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
// Directed bench for alu_op_sequencer: reset state, each operation, signed
// LESS corner cases, backpressure with a pending request, and reset while
// an operation is in flight. Latency is counted in cycles from the accept
// cycle (cycle 0 = cycle in which op_valid & op_ready is sampled).
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    alu_op_sequencer_if #(.WIDTH(24)) bus ();

    alu_op_sequencer #(.WIDTH(24)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          lat;
    logic [23:0] r;
    logic        c;
    logic        z;
    logic [1:0]  ms;

    // Issue one op with res_ready high; returns the cycle in which res_valid
    // was first seen (0 on timeout) and the outputs sampled in that cycle.
    task automatic do_op(input logic [1:0] code, input logic sub,
                         input logic [23:0] a, input logic [23:0] b,
                         output int lat_o, output logic [23:0] res_o,
                         output logic c_o, output logic z_o, output logic [1:0] ms_o);
        @(negedge clk);
        bus.op_code   = code;
        bus.op_sub    = sub;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.res_ready = 1'b1;
        bus.op_valid  = 1'b1;
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
        lat_o = 0; res_o = '0; c_o = 1'b0; z_o = 1'b0; ms_o = 2'b00;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) begin
                lat_o = i; res_o = bus.result; c_o = bus.carry_out;
                z_o = bus.zero; ms_o = bus.mux_sel;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        checks++; if (bus.op_ready !== 1'b1) begin failures++; $display("FAIL reset_op_ready got=%b exp=1", bus.op_ready); end
        checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
        checks++; if (bus.result !== 24'h0) begin failures++; $display("FAIL reset_result got=%h exp=000000", bus.result); end
        checks++; if ({bus.mux_sel, bus.carry_out, bus.zero} !== 4'b0000) begin failures++; $display("FAIL reset_misc got=%b exp=0000", {bus.mux_sel, bus.carry_out, bus.zero}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.op_ready !== 1'b1) begin failures++; $display("FAIL post_reset_op_ready got=%b exp=1", bus.op_ready); end
    endtask

    task automatic test_and();
        do_op(2'b00, 1'b0, 24'hF0F0F0, 24'hFF00FF, lat, r, c, z, ms);
        checks++; if (lat !== 2) begin failures++; $display("FAIL and_latency got=%0d exp=2", lat); end
        checks++; if (r !== 24'hF000F0) begin failures++; $display("FAIL and_result got=%h exp=f000f0", r); end
        checks++; if ({ms, c, z} !== 4'b0000) begin failures++; $display("FAIL and_flags got=%b exp=0000", {ms, c, z}); end
        // res_ready was high on entry to DONE: result visible one cycle only.
        @(negedge clk);
        checks++; if ({bus.res_valid, bus.op_ready, bus.mux_sel} !== 4'b0100) begin failures++; $display("FAIL and_release got=%b exp=0100", {bus.res_valid, bus.op_ready, bus.mux_sel}); end
    endtask

    task automatic test_or();
        do_op(2'b01, 1'b1, 24'h123400, 24'h000056, lat, r, c, z, ms);
        checks++; if (r !== 24'h123456) begin failures++; $display("FAIL or_result got=%h exp=123456", r); end
        checks++; if ({ms, c, z} !== 4'b0100) begin failures++; $display("FAIL or_flags got=%b exp=0100", {ms, c, z}); end
    endtask

    task automatic test_add_sub();
        do_op(2'b10, 1'b0, 24'hFFFFFF, 24'h000001, lat, r, c, z, ms);
        checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end
        checks++; if (r !== 24'h000000) begin failures++; $display("FAIL add_wrap_result got=%h exp=000000", r); end
        checks++; if ({ms, c, z} !== 4'b1011) begin failures++; $display("FAIL add_wrap_flags got=%b exp=1011", {ms, c, z}); end
        do_op(2'b10, 1'b1, 24'h000005, 24'h000007, lat, r, c, z, ms);
        checks++; if (r !== 24'hFFFFFE) begin failures++; $display("FAIL sub_result got=%h exp=fffffe", r); end
        checks++; if ({ms, c, z} !== 4'b1000) begin failures++; $display("FAIL sub_flags got=%b exp=1000", {ms, c, z}); end
        do_op(2'b10, 1'b1, 24'h000009, 24'h000004, lat, r, c, z, ms);
        checks++; if ({r, c} !== {24'h000005, 1'b1}) begin failures++; $display("FAIL sub_noborrow got=%h/%b exp=000005/1", r, c); end
    endtask

    task automatic test_less();
        do_op(2'b11, 1'b0, 24'h800000, 24'h000001, lat, r, c, z, ms);
        checks++; if (lat !== 3) begin failures++; $display("FAIL less_latency got=%0d exp=3", lat); end
        checks++; if (r !== 24'h000001) begin failures++; $display("FAIL less_neg_result got=%h exp=000001", r); end
        checks++; if ({ms, c, z} !== 4'b1100) begin failures++; $display("FAIL less_neg_flags got=%b exp=1100", {ms, c, z}); end
        do_op(2'b11, 1'b0, 24'h7FFFFF, 24'h800000, lat, r, c, z, ms);
        checks++; if (r !== 24'h000000) begin failures++; $display("FAIL less_ovf_result got=%h exp=000000", r); end
        checks++; if ({ms, c, z} !== 4'b1101) begin failures++; $display("FAIL less_ovf_flags got=%b exp=1101", {ms, c, z}); end
        do_op(2'b11, 1'b1, 24'h000005, 24'h000007, lat, r, c, z, ms);
        checks++; if (r !== 24'h000001) begin failures++; $display("FAIL less_small_result got=%h exp=000001", r); end
        do_op(2'b11, 1'b0, 24'h000007, 24'h000007, lat, r, c, z, ms);
        checks++; if ({r, z} !== {24'h000000, 1'b1}) begin failures++; $display("FAIL less_equal got=%h/%b exp=000000/1", r, z); end
    endtask

    task automatic test_back_to_back();
        int waited;
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.op_code = 2'b00; bus.op_sub = 1'b0;
        bus.operand_a = 24'h00FF00; bus.operand_b = 24'h0FF000;
        bus.op_valid = 1'b1;
        @(posedge clk);
        // Next request pending while the first is in flight.
        #1;
        bus.op_code = 2'b01; bus.operand_a = 24'h000001; bus.operand_b = 24'h000002;
        waited = 0;
        while (bus.res_valid !== 1'b1 && waited < 10) begin @(negedge clk); waited++; end
        checks++; if (bus.res_valid !== 1'b1) begin failures++; $display("FAIL bp_reach_done got=%b exp=1 after %0d cycles", bus.res_valid, waited); end
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            checks++; if ({bus.result, bus.op_ready, bus.res_valid} !== {24'h00F000, 1'b0, 1'b1}) begin
                failures++; $display("FAIL bp_hold cycle=%0d got=%h/%b/%b exp=00f000/0/1", i, bus.result, bus.op_ready, bus.res_valid);
            end
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        checks++; if ({bus.op_ready, bus.res_valid} !== 2'b10) begin failures++; $display("FAIL bp_idle got=%b exp=10", {bus.op_ready, bus.res_valid}); end
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
        @(negedge clk);
        checks++; if ({bus.op_ready, bus.mux_sel} !== 3'b001) begin failures++; $display("FAIL bp_pending_accept got=%b exp=001", {bus.op_ready, bus.mux_sel}); end
        @(negedge clk);
        checks++; if ({bus.res_valid, bus.result} !== {1'b1, 24'h000003}) begin failures++; $display("FAIL bp_second_result got=%b/%h exp=1/000003", bus.res_valid, bus.result); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_cmp();
        @(negedge clk);
        bus.res_ready = 1'b1;
        bus.op_code = 2'b11; bus.op_sub = 1'b0;
        bus.operand_a = 24'h800000; bus.operand_b = 24'h000001;
        bus.op_valid = 1'b1;
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
        @(posedge clk);
        #2;
        checks++; if ({bus.op_ready, bus.mux_sel, bus.result} !== {1'b0, 2'b11, 24'h000003}) begin
            failures++; $display("FAIL cmp_state got=%b/%b/%h exp=0/11/000003", bus.op_ready, bus.mux_sel, bus.result);
        end
        rst = 1'b1;
        #1;
        checks++; if ({bus.res_valid, bus.op_ready, bus.mux_sel} !== 4'b0100) begin failures++; $display("FAIL rst_cmp_ctrl got=%b exp=0100", {bus.res_valid, bus.op_ready, bus.mux_sel}); end
        checks++; if ({bus.result, bus.carry_out, bus.zero} !== 26'h0) begin failures++; $display("FAIL rst_cmp_data got=%h exp=0", {bus.result, bus.carry_out, bus.zero}); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL rst_cmp_no_result cycle=%0d got=%b exp=0", i, bus.res_valid); end
        end
        do_op(2'b00, 1'b0, 24'h0000FF, 24'h00000F, lat, r, c, z, ms);
        checks++; if ({lat[3:0], r} !== {4'd2, 24'h00000F}) begin failures++; $display("FAIL rst_cmp_recover got=%0d/%h exp=2/00000f", lat, r); end
    endtask

    initial begin
        bus.op_valid  = 1'b0;
        bus.op_code   = 2'b00;
        bus.op_sub    = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_and();
        test_or();
        test_add_sub();
        test_less();
        test_back_to_back();
        test_reset_in_cmp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
